// File: rtl/muxn_pkg.sv
// muxn_pkg: default constants shared by the muxn_pipe slice (no ports)
package muxn_pkg;
  localparam int MUXN_DEF_WIDTH = 32;
  localparam int MUXN_DEF_N = 4;
endpackage

// File: rtl/muxn_skid_reg.sv
// muxn_skid_reg: OUT/SKID register pair; in_* stream accepted when SKID empty, out_* stream from OUT, flush_i drops both entries
module muxn_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, acc, xfer;
  assign in_ready_o = !skid_v_q;
  assign out_data_o = out_q;
  assign out_valid_o = out_v_q;
  always_comb begin
    acc = in_valid_i && !skid_v_q;
    xfer = out_v_q && out_ready_i;
    out_d = (skid_v_q && xfer) ? skid_q : (acc && (!out_v_q || xfer)) ? in_data_i : out_q;
    skid_d = (acc && out_v_q && !xfer) ? in_data_i : skid_q;
    out_v_d = !flush_i && (acc || skid_v_q || (out_v_q && !xfer));
    skid_v_d = !flush_i && ((acc && out_v_q && !xfer) || (skid_v_q && !xfer));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      skid_q <= '0;
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end
endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-way word select feeding a 2-entry skid pipe; d/s/in_valid/in_ready in, y/out_valid/out_ready out, flush, sticky sel_err
module muxn_pipe import muxn_pkg::*; #(
  parameter int WIDTH = MUXN_DEF_WIDTH,
  parameter int N = MUXN_DEF_N,
  parameter int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    s,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);
  logic [WIDTH-1:0] sel_word;
  logic sel_err_q, sel_err_d;
  always_comb begin
    sel_word = d[WIDTH-1:0];
    for (int i = 1; i < N; i++) sel_word = (s == SELW'(i)) ? d[i*WIDTH +: WIDTH] : sel_word;
    sel_err_d = sel_err_q || (in_valid && in_ready && (32'(s) >= N));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else sel_err_q <= sel_err_d;
  end
  assign sel_err = sel_err_q;
  muxn_skid_reg #(.WIDTH(WIDTH)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .in_data_i(sel_word),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_data_o(y),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );
endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: self-checking bench for muxn_pipe (vector table, directed corner sequences, randomized scoreboard)
module tb_muxn_pipe;
  logic clk, rst_n;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] a_d;
  logic [1:0] a_s;
  logic a_iv, a_rdy, a_fl, a_ov, a_or, a_err;
  logic [7:0] a_y;
  logic [23:0] b_d;
  logic [1:0] b_s;
  logic b_iv, b_rdy, b_fl, b_ov, b_or, b_err;
  logic [7:0] b_y;
  logic [127:0] c_d;
  logic [2:0] c_s;
  logic c_iv, c_rdy, c_fl, c_ov, c_or, c_err;
  logic [15:0] c_y;
  muxn_pipe #(.WIDTH(8), .N(4)) dut_a (.clk(clk), .rst_n(rst_n), .d(a_d), .s(a_s), .in_valid(a_iv), .in_ready(a_rdy),
    .flush(a_fl), .y(a_y), .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err));
  muxn_pipe #(.WIDTH(8), .N(3)) dut_b (.clk(clk), .rst_n(rst_n), .d(b_d), .s(b_s), .in_valid(b_iv), .in_ready(b_rdy),
    .flush(b_fl), .y(b_y), .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err));
  muxn_pipe #(.WIDTH(16), .N(8)) dut_c (.clk(clk), .rst_n(rst_n), .d(c_d), .s(c_s), .in_valid(c_iv), .in_ready(c_rdy),
    .flush(c_fl), .y(c_y), .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic       iv;
    logic [1:0] s;
    logic       ordy;
    logic       chk_y;
    logic       ev;
    logic [7:0] ey;
    logic       er;
  } vec_t;
  vec_t tv[10];
  initial begin
    logic [15:0] q[$];
    int acc_n, cyc, n0;
    tv[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    tv[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
    tv[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
    tv[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1};
    tv[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tv[5] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    tv[6] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    tv[7] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    tv[8] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
    tv[9] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    a_d = 32'h44332211; a_s = '0; a_iv = 0; a_fl = 0; a_or = 0;
    b_d = 24'h3322A5; b_s = '0; b_iv = 0; b_fl = 0; b_or = 0;
    c_d = '0; c_s = '0; c_iv = 0; c_fl = 0; c_or = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, a_ov}, 0);
    chk("rst_in_ready", {31'b0, a_rdy}, 1);
    chk("rst_y", {24'b0, a_y}, 0);
    chk("rst_sel_err", {31'b0, a_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_iv = tv[i].iv; a_s = tv[i].s; a_or = tv[i].ordy;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, a_ov}, {31'b0, tv[i].ev});
      chk($sformatf("vec%0d_in_ready", i), {31'b0, a_rdy}, {31'b0, tv[i].er});
      if (tv[i].chk_y) chk($sformatf("vec%0d_y", i), {24'b0, a_y}, {24'b0, tv[i].ey});
    end
    a_iv = 1; a_s = 0; a_or = 0;
    step();
    a_s = 1;
    step();
    a_iv = 0;
    chk("mid_full_valid", {31'b0, a_ov}, 1);
    chk("mid_full_in_ready", {31'b0, a_rdy}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, a_ov}, 0);
    chk("async_rst_in_ready", {31'b0, a_rdy}, 1);
    chk("async_rst_y", {24'b0, a_y}, 0);
    chk("async_rst_sel_err", {31'b0, a_err}, 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_valid", {31'b0, a_ov}, 0);
    a_iv = 1; a_s = 0; a_or = 0;
    step();
    a_s = 1;
    step();
    a_s = 2; a_fl = 1;
    step();
    a_fl = 0; a_iv = 0; a_or = 1;
    chk("flush_full_valid", {31'b0, a_ov}, 0);
    chk("flush_full_in_ready", {31'b0, a_rdy}, 1);
    step();
    chk("flush_full_after_valid", {31'b0, a_ov}, 0);
    a_iv = 1; a_s = 3; a_or = 0;
    step();
    chk("one_held_y", {24'b0, a_y}, 8'h44);
    a_s = 2; a_fl = 1; a_or = 1;
    step();
    a_fl = 0; a_iv = 0;
    chk("flush_acc_valid", {31'b0, a_ov}, 0);
    chk("flush_acc_in_ready", {31'b0, a_rdy}, 1);
    step();
    chk("flush_acc_lost", {31'b0, a_ov}, 0);
    b_iv = 1; b_s = 1; b_or = 0;
    step();
    b_s = 2;
    step();
    b_s = 3;
    step();
    chk("oor_blocked_in_ready", {31'b0, b_rdy}, 0);
    chk("oor_blocked_sel_err", {31'b0, b_err}, 0);
    b_iv = 0; b_fl = 1;
    step();
    b_fl = 0;
    chk("oor_flush_valid", {31'b0, b_ov}, 0);
    chk("oor_not_accepted_err", {31'b0, b_err}, 0);
    b_iv = 1; b_s = 3; b_or = 1;
    step();
    b_iv = 0;
    chk("oor_y", {24'b0, b_y}, 8'hA5);
    chk("oor_valid", {31'b0, b_ov}, 1);
    chk("oor_sel_err", {31'b0, b_err}, 1);
    b_fl = 1;
    step();
    b_fl = 0;
    chk("oor_err_after_flush", {31'b0, b_err}, 1);
    b_iv = 1; b_s = 1;
    step();
    b_iv = 0;
    chk("oor_legal_y", {24'b0, b_y}, 8'h22);
    chk("oor_err_sticky", {31'b0, b_err}, 1);
    acc_n = 0;
    cyc = 0;
    while ((acc_n < 10000 || q.size() != 0) && cyc < 60000) begin
      n0 = q.size();
      c_iv = (acc_n < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      c_or = 1'($urandom_range(0, 1));
      c_s = 3'($urandom_range(0, 7));
      c_d = {$urandom, $urandom, $urandom, $urandom};
      if (c_or && n0 > 0) void'(q.pop_front());
      if (c_iv && n0 < 2) begin
        q.push_back(c_d[c_s*16 +: 16]);
        acc_n++;
      end
      step();
      cyc++;
      chk("rand_in_ready", {31'b0, c_rdy}, {31'b0, q.size() < 2});
      chk("rand_valid", {31'b0, c_ov}, {31'b0, q.size() > 0});
      if (q.size() > 0) chk("rand_y", {16'b0, c_y}, {16'b0, q[0]});
    end
    c_iv = 0;
    chk("rand_complete", {31'b0, (acc_n == 10000) && (q.size() == 0)}, 1);
    chk("rand_sel_err", {31'b0, c_err}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 Parameter N, default 4, number of data inputs; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N), select width, derived and never overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 d  input  N*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
REQ-007 s  input  SELW  select for the current beat.
REQ-008 in_valid  input  1  upstream beat (d, s) valid.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 flush  input  1  synchronous discard of all held beats.
REQ-011 y  output  WIDTH  selected data of the head beat.
REQ-012 out_valid  output  1  y holds a valid beat.
REQ-013 out_ready  input  1  downstream accepts y this cycle.
REQ-014 sel_err  output  1  sticky flag: a beat with s >= N was accepted.

Function
REQ-015 Accept occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-016 The selected word is d[s] for s < N; for s >= N it is d[0] (input 0 is the default leg).
REQ-017 Storage is two entries: output register (OUT) and skid register (SKID), each a WIDTH word plus valid bit.
REQ-018 in_ready is a pure function of registered state: high iff SKID is empty; no combinational path from out_ready to in_ready.
REQ-019 Latency is exactly 1 cycle: a beat accepted into an empty OUT appears on y with out_valid the next cycle.
REQ-020 On accept: if OUT empty or OUT transferring this cycle (and SKID empty), the beat loads OUT; otherwise it loads SKID.
REQ-021 On transfer with SKID full, SKID moves to OUT and SKID empties in the same edge; SKID cannot be loaded that cycle because in_ready was low.
REQ-022 Beats leave in acceptance order; no beat is dropped or duplicated except by flush or reset.
REQ-023 Full sustained throughput: with in_valid and out_ready both held high, one beat per cycle after the first.
REQ-024 y and out_valid hold steady while out_valid && !out_ready.
REQ-025 flush clears both valid bits at the next edge; flush wins over a simultaneous accept (beat discarded) and over a simultaneous transfer (transfer still counts for downstream).
REQ-026 flush does not clear sel_err.
REQ-027 sel_err sets on the edge after an accept with s >= N and stays set until reset; discarded (non-accepted) beats never set it.
REQ-028 y is don't-care while out_valid is low but shall be driven from OUT data, never from a latch.

Reset
REQ-029 Asserting rst_n low immediately clears OUT and SKID valid bits, sel_err, and OUT/SKID data to 0, regardless of clk.
REQ-030 During reset out_valid = 0, y = 0, sel_err = 0, in_ready = 1; a beat in flight when reset asserts is lost.
REQ-031 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds default constants MUXN_DEF_WIDTH = 32 and MUXN_DEF_N = 4; no other typedefs required.
REQ-033 The N-way select shall be a combinational case/index function inside the module; one sub-module, muxn_skid_reg (the OUT/SKID pair with handshake), is natural and permitted.

Verification
REQ-034 Reset: rst_n low mid-stream with OUT and SKID full -> out_valid=0, in_ready=1, y=0, sel_err=0 immediately, no clk needed.
REQ-035 Streaming: N=4, d={0x44,0x33,0x22,0x11}, s=0,1,2,3 on consecutive cycles, out_ready=1 -> y=0x11,0x22,0x33,0x44 on cycles 1..4, out_valid continuous.
REQ-036 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> OUT then SKID fill, in_ready low from cycle 2, y frozen; out_ready=1 -> both beats drain in order, in_ready rises one cycle after first transfer.
REQ-037 Out-of-range: N=3, SELW=2, s=3, d0=0xA5 -> y=0xA5 next cycle, sel_err=1 and stays 1 after flush and further legal beats.
REQ-038 Flush collision: OUT and SKID full, flush=1 with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, flushed input beat never appears.
REQ-039 Random: constrained-random in_valid/out_ready at 50% each, 10,000 beats, N=8, WIDTH=16 -> scoreboard matches order and values, zero loss.
